// File: rtl/arb_req_pkg.sv
// Shared state encodings and default sizing for the req/gnt requester agent.
package arb_req_pkg;

  localparam int LEN_W_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_XFER = 4'b0100,
    ST_REL  = 4'b1000
  } state_t;

endpackage

// File: rtl/arb_req_fifo.sv
// Job-length FIFO for the requester: synchronous, power-of-two depth, head visible combinationally.
module arb_req_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the simultaneous push needs, so push is legal when full if popping.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for the two-requester arbiter: queues jobs, requests the bus,
// issues a counted burst while granted, then releases and waits for the grant to drop.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic [LEN_W-1:0] beat_idx,
  output logic             last,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LEN_W-1:0] head_len;

  assign job_ready = !fifo_full && !rst;
  assign fifo_push = job_valid && job_ready;

  arb_req_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (job_len),
    .pop   (fifo_pop),
    .rdata (head_len),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Burst outputs follow gnt combinationally so a mid-burst grant gap stalls the same cycle.
  assign beat     = (state_q == ST_XFER) && gnt;
  assign beat_idx = cnt_q;
  assign last     = beat && (cnt_q == head_len);
  assign req      = req_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // A grant seen on the final wait cycle beats the timeout; a timed-out job stays queued.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          state_d = ST_XFER;
          cnt_d   = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = ST_REL;
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (gnt) begin
          if (cnt_q == head_len) begin
            state_d  = ST_REL;
            req_d    = 1'b0;
            done_d   = 1'b1;
            fifo_pop = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_REL: begin
        if (!gnt) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench: two requesters on a registered priority arbiter, checked against a queue-based model.
module tb_arb_requester;

  localparam int LEN_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_off = 1'b0;
  logic [1:0] job_valid = '0;
  logic [1:0][LEN_W-1:0] job_len = '0;
  logic [1:0] job_ready, req, beat, last, done, timeout, busy;
  logic [1:0][LEN_W-1:0] beat_idx;
  logic [1:0] gnt = '0;

  int tests = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model state per requester
  int mq [2][$];
  bit m_req [2];
  bit m_burst [2];
  bit m_rel [2];
  bit m_done [2];
  bit m_to [2];
  int m_beats [2];
  int m_wait [2];

  always #5 clk = ~clk;

  arb_requester #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .rst(rst), .job_valid(job_valid[0]), .job_len(job_len[0]),
    .job_ready(job_ready[0]), .req(req[0]), .gnt(gnt[0]), .beat(beat[0]),
    .beat_idx(beat_idx[0]), .last(last[0]), .done(done[0]), .timeout(timeout[0]),
    .busy(busy[0]));

  arb_requester #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst(rst), .job_valid(job_valid[1]), .job_len(job_len[1]),
    .job_ready(job_ready[1]), .req(req[1]), .gnt(gnt[1]), .beat(beat[1]),
    .beat_idx(beat_idx[1]), .last(last[1]), .done(done[1]), .timeout(timeout[1]),
    .busy(busy[1]));

  // Registered arbiter: holder keeps the bus while requesting, requester 0 wins ties.
  always @(posedge clk) begin
    if (rst || hold_off)        gnt <= 2'b00;
    else if (gnt[0] && req[0])  gnt <= 2'b01;
    else if (gnt[1] && req[1])  gnt <= 2'b10;
    else if (req[0])            gnt <= 2'b01;
    else if (req[1])            gnt <= 2'b10;
    else                        gnt <= 2'b00;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v0, input int l0, input bit v1, input int l1, input bit hold);
    job_valid  = {v1, v0};
    job_len[0] = LEN_W'(l0);
    job_len[1] = LEN_W'(l1);
    hold_off   = hold;
  endtask

  task automatic model_compare(input int i);
    int  sz;
    bit  exp_beat;
    bit  exp_last;
    sz       = mq[i].size();
    exp_beat = m_burst[i] && gnt[i];
    exp_last = exp_beat && (m_beats[i] == mq[i][0]);
    checkOutput($sformatf("dut%0d_req", i), req[i], m_req[i]);
    checkOutput($sformatf("dut%0d_beat", i), beat[i], exp_beat);
    checkOutput($sformatf("dut%0d_last", i), last[i], exp_last);
    checkOutput($sformatf("dut%0d_done", i), done[i], m_done[i]);
    checkOutput($sformatf("dut%0d_timeout", i), timeout[i], m_to[i]);
    checkOutput($sformatf("dut%0d_busy", i), busy[i], m_req[i] || m_rel[i] || (sz > 0));
    checkOutput($sformatf("dut%0d_job_ready", i), job_ready[i], !rst && (sz < DEPTH));
    if (exp_beat) checkOutput($sformatf("dut%0d_beat_idx", i), beat_idx[i], m_beats[i]);
  endtask

  task automatic model_step(input int i);
    int sz;
    bit accept;
    if (rst) begin
      mq[i].delete();
      m_req[i] = 0; m_burst[i] = 0; m_rel[i] = 0; m_done[i] = 0; m_to[i] = 0;
      m_beats[i] = 0; m_wait[i] = 0;
      return;
    end
    sz = mq[i].size();
    accept = job_valid[i] && (sz < DEPTH);
    m_done[i] = 0;
    m_to[i] = 0;
    if (m_rel[i]) begin
      if (!gnt[i]) m_rel[i] = 0;
    end else if (m_burst[i]) begin
      if (gnt[i]) begin
        if (m_beats[i] == mq[i][0]) begin
          m_done[i] = 1;
          void'(mq[i].pop_front());
          m_burst[i] = 0;
          m_req[i] = 0;
          m_rel[i] = 1;
        end else begin
          m_beats[i]++;
        end
      end
    end else if (m_req[i]) begin
      if (gnt[i]) begin
        m_burst[i] = 1;
        m_beats[i] = 0;
      end else if (m_wait[i] == TIMEOUT - 1) begin
        m_to[i] = 1;
        m_req[i] = 0;
        m_rel[i] = 1;
      end else begin
        m_wait[i]++;
      end
    end else if (sz > 0) begin
      m_req[i] = 1;
      m_wait[i] = 0;
    end
    if (accept) mq[i].push_back(int'(job_len[i]));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) model_compare(i);
      checkOutput("beat_overlap", beat[0] && beat[1], 0);
      checkOutput("grant_overlap", gnt[0] && gnt[1], 0);
    end
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    applyStimulus(0, 0, 0, 0, 0);
    while (n < 300) begin
      @(negedge clk);
      if (busy == 2'b00 && gnt == 2'b00) break;
      next_cycle();
      n++;
    end
    checkOutput({tag, "_idle_bound"}, n < 300, 1);
    next_cycle();
  endtask

  task automatic test_single();
    int first_req, first_beat, nbeats, last_cyc, done_cyc, idle_cyc;
    first_req = -1; first_beat = -1; nbeats = 0; last_cyc = -1; done_cyc = -1; idle_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) applyStimulus(1, 3, 0, 0, 0);
      else        applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      if (req[0] && first_req < 0) first_req = k;
      if (beat[0]) begin
        nbeats++;
        if (first_beat < 0) first_beat = k;
        if (k == 5) checkOutput("single_idx_c5", beat_idx[0], 1);
      end
      if (last[0] && last_cyc < 0) last_cyc = k;
      if (done[0] && done_cyc < 0) done_cyc = k;
      if (!busy[0] && k > 1 && idle_cyc < 0) idle_cyc = k;
      next_cycle();
    end
    checkOutput("single_req_rise", first_req, 2);
    checkOutput("single_first_beat", first_beat, 4);
    checkOutput("single_beats", nbeats, 4);
    checkOutput("single_last", last_cyc, 7);
    checkOutput("single_done", done_cyc, 8);
    checkOutput("single_idle", idle_cyc, 10);
  endtask

  task automatic test_queue_full();
    int lens[5] = '{1, 2, 3, 4, 5};
    int got[$];
    int cnt, n;
    cnt = 0; n = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, lens[k], 0, 0, 1);
      @(negedge clk);
      checkOutput($sformatf("qfull_ready_%0d", k), job_ready[0], k < 4);
      next_cycle();
    end
    applyStimulus(0, 0, 0, 0, 0);
    while (got.size() < 4 && n < 400) begin
      @(negedge clk);
      if (beat[0]) begin
        cnt++;
        if (last[0]) begin
          got.push_back(cnt);
          cnt = 0;
        end
      end
      next_cycle();
      n++;
    end
    checkOutput("qfull_jobs_done", got.size(), 4);
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("qfull_beats_%0d", j), (j < got.size()) ? got[j] : 0, lens[j] + 1);
  endtask

  task automatic test_timeout();
    int first_req, to_cyc, rerise, n;
    bit req_at_to, seen_done;
    first_req = -1; to_cyc = -1; rerise = -1; req_at_to = 1; seen_done = 0; n = 0;
    for (int k = 0; k < 26; k++) begin
      applyStimulus(k == 0, 2, 0, 0, 1);
      @(negedge clk);
      if (req[0] && first_req < 0) first_req = k;
      if (timeout[0] && to_cyc < 0) begin
        to_cyc = k;
        req_at_to = req[0];
      end
      if (to_cyc >= 0 && k > to_cyc && req[0] && rerise < 0) rerise = k;
      next_cycle();
    end
    checkOutput("timeout_req_rise", first_req, 2);
    checkOutput("timeout_pulse", to_cyc, 17);
    checkOutput("timeout_req_drop", req_at_to, 0);
    checkOutput("timeout_retry", rerise, 19);
    applyStimulus(0, 0, 0, 0, 0);
    while (!seen_done && n < 80) begin
      @(negedge clk);
      if (done[0]) seen_done = 1;
      next_cycle();
      n++;
    end
    checkOutput("timeout_retry_done", seen_done, 1);
  endtask

  task automatic test_gap();
    int nbeats;
    nbeats = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k == 0, 4, 0, 0, (k == 4) || (k == 5));
      @(negedge clk);
      if (beat[0]) nbeats++;
      if (k == 5 || k == 6) begin
        checkOutput($sformatf("gap_beat_c%0d", k), beat[0], 0);
        checkOutput($sformatf("gap_idx_c%0d", k), beat_idx[0], 1);
      end
      next_cycle();
    end
    checkOutput("gap_total_beats", nbeats, 5);
  endtask

  task automatic test_reset_mid();
    int ndone_pre, ndone_post;
    ndone_pre = 0; ndone_post = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 3)       applyStimulus(1, 3, 0, 0, 0);
      else if (k == 9) applyStimulus(1, 1, 0, 0, 0);
      else             applyStimulus(0, 0, 0, 0, 0);
      rst = (k == 6);
      @(negedge clk);
      if (k == 6) begin
        checkOutput("rstmid_idx", beat_idx[0], 2);
        checkOutput("rstmid_ready_in_rst", job_ready[0], 0);
      end
      if (k == 7) begin
        checkOutput("rstmid_req", req[0], 0);
        checkOutput("rstmid_busy", busy[0], 0);
        checkOutput("rstmid_ready_after", job_ready[0], 1);
      end
      if (done[0] && k >= 6 && k < 9) ndone_pre++;
      if (done[0] && k >= 9) ndone_post++;
      next_cycle();
    end
    checkOutput("rstmid_no_done", ndone_pre, 0);
    checkOutput("rstmid_new_job_done", ndone_post, 1);
  endtask

  task automatic test_two();
    int b0, b1, d0, d1;
    b0 = -1; b1 = -1; d0 = -1; d1 = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0, 2, k == 0, 2, 0);
      @(negedge clk);
      if (beat[0] && b0 < 0) b0 = k;
      if (beat[1] && b1 < 0) b1 = k;
      if (done[0] && d0 < 0) d0 = k;
      if (done[1] && d1 < 0) d1 = k;
      next_cycle();
    end
    checkOutput("two_first_beat0", b0, 4);
    checkOutput("two_done0", d0, 7);
    checkOutput("two_first_beat1", b1, 9);
    checkOutput("two_done1", d1, 12);
  endtask

  task automatic test_random();
    bit hold;
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) hold = !hold;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 15), hold);
      next_cycle();
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ready_in_reset", job_ready[0], 0);
    next_cycle();
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_req", req[0], 0);
    checkOutput("rst_beat", beat[0], 0);
    checkOutput("rst_beat_idx", beat_idx[0], 0);
    checkOutput("rst_last", last[0], 0);
    checkOutput("rst_done", done[0], 0);
    checkOutput("rst_timeout", timeout[0], 0);
    checkOutput("rst_busy", busy[0], 0);
    checkOutput("rst_job_ready", job_ready[0], 1);
    next_cycle();

    wait_idle("pre_single");
    test_single();
    wait_idle("pre_qfull");
    test_queue_full();
    wait_idle("pre_timeout");
    test_timeout();
    wait_idle("pre_gap");
    test_gap();
    wait_idle("pre_rst");
    test_reset_mid();
    wait_idle("pre_two");
    test_two();
    wait_idle("pre_random");
    test_random();
    wait_idle("drain");
    checkOutput("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
